// File: rtl/apb_pwm_bank.sv
// APB3-mapped bank of NCH independent PWM channels with shadowed period/duty,
// wrap interrupts (W1C status) and a multi-channel counter restart register.
module apb_pwm_bank #(
  parameter int unsigned NCH = 4,
  parameter int unsigned CW  = 24
) (
  input  logic           PCLK,
  input  logic           PRESET,
  input  logic           PSEL,
  input  logic           PENABLE,
  input  logic           PWRITE,
  input  logic [31:0]    PADDR,
  input  logic [31:0]    PWDATA,
  output logic [31:0]    PRDATA,
  output logic           PREADY,
  output logic           PSLVERR,
  output logic [NCH-1:0] PWM_OUT,
  output logic           PWM_IRQ
);

  localparam int unsigned CTRL_W = 3;

  logic [CTRL_W-1:0] ctrl     [NCH];
  logic [CW-1:0]     per_sh   [NCH];
  logic [CW-1:0]     duty_sh  [NCH];
  logic [CW-1:0]     per_act  [NCH];
  logic [CW-1:0]     duty_act [NCH];
  logic [CW-1:0]     cnt      [NCH];
  logic [NCH-1:0]    irq_stat;

  logic [11:0]    off;
  logic [1:0]     rsel;
  logic           access;
  logic           is_stat;
  logic           is_sync;
  logic           wr_ok;
  logic [NCH-1:0] ch_hit;
  logic [NCH-1:0] run;
  logic [NCH-1:0] wrap;
  logic [NCH-1:0] ie;
  logic           unused_bits;

  assign off         = PADDR[11:0];
  assign rsel        = off[3:2];
  assign access      = PSEL & PENABLE;
  assign is_stat     = (off == 12'h100);
  assign is_sync     = (off == 12'h104);
  assign PREADY      = 1'b1;
  assign unused_bits = ^{PADDR[31:12], PWDATA};

  // Address decode, error response and read mux
  always_comb begin
    ch_hit = '0;
    for (int n = 0; n < int'(NCH); n++) begin
      if (off[11:4] == 8'(n) && off[1:0] == 2'b00) ch_hit[n] = 1'b1;
    end
    PSLVERR = access & (~(|ch_hit | is_stat | is_sync) |
                        (PWRITE & (|ch_hit) & (rsel == 2'd3)));
    wr_ok   = access & PWRITE & ~PSLVERR;
    PRDATA  = '0;
    if (access) begin
      for (int n = 0; n < int'(NCH); n++) begin
        if (ch_hit[n]) begin
          case (rsel)
            2'd0:    PRDATA = 32'(ctrl[n]);
            2'd1:    PRDATA = 32'(per_sh[n]);
            2'd2:    PRDATA = 32'(duty_sh[n]);
            default: PRDATA = 32'(cnt[n]);
          endcase
        end
      end
      if (is_stat) PRDATA = 32'(irq_stat);
    end
  end

  // Per-channel run/wrap qualifiers
  always_comb begin
    for (int n = 0; n < int'(NCH); n++) begin
      run[n]  = ctrl[n][0] && (per_act[n] != '0);
      wrap[n] = run[n] && (cnt[n] == per_act[n] - CW'(1));
      ie[n]   = ctrl[n][2];
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      for (int n = 0; n < int'(NCH); n++) begin
        ctrl[n]     <= '0;
        per_sh[n]   <= '0;
        duty_sh[n]  <= '0;
        per_act[n]  <= '0;
        duty_act[n] <= '0;
        cnt[n]      <= '0;
      end
      irq_stat <= '0;
      PWM_OUT  <= '0;
      PWM_IRQ  <= 1'b0;
    end else begin
      for (int n = 0; n < int'(NCH); n++) begin
        if (wr_ok && ch_hit[n]) begin
          case (rsel)
            2'd0:    ctrl[n]    <= PWDATA[CTRL_W-1:0];
            2'd1:    per_sh[n]  <= PWDATA[CW-1:0];
            2'd2:    duty_sh[n] <= PWDATA[CW-1:0];
            default: ;
          endcase
        end
        // Active values follow the shadows while idle, else only at wrap
        if (!ctrl[n][0] || wrap[n]) begin
          per_act[n]  <= per_sh[n];
          duty_act[n] <= duty_sh[n];
        end
        if (!run[n] || wrap[n] || (wr_ok && is_sync && PWDATA[n]))
          cnt[n] <= '0;
        else
          cnt[n] <= cnt[n] + CW'(1);
        PWM_OUT[n]  <= run[n] ? ((cnt[n] < duty_act[n]) ^ ctrl[n][1]) : ctrl[n][1];
        // A wrap on the same edge as a W1C keeps the bit set
        irq_stat[n] <= wrap[n] | (irq_stat[n] & ~(wr_ok & is_stat & PWDATA[n]));
      end
      PWM_IRQ <= |(irq_stat & ie);
    end
  end

endmodule

// File: tb/tb_apb_pwm_bank.sv
// Directed self-checking bench for apb_pwm_bank (NCH=4, CW=24) using
// immediate assertions at every check point.
module tb_apb_pwm_bank;

  logic        PCLK;
  logic        PRESET;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic [3:0]  PWM_OUT;
  logic        PWM_IRQ;

  int errors;
  int checks;
  logic [31:0] rdat;
  logic        err;
  logic [9:0]  pat40;
  logic [13:0] pat41;

  apb_pwm_bank #(.NCH(4), .CW(24)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .PWM_OUT(PWM_OUT), .PWM_IRQ(PWM_IRQ)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Setup + access phase; called at a negedge, returns at the negedge after the write edge
  task automatic wr(input logic [31:0] a, input logic [31:0] d, output logic e);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1 e = PSLVERR;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic w(input logic [31:0] a, input logic [31:0] d);
    logic e;
    wr(a, d, e);
  endtask

  // Combinational read inside the low phase; no clock edge passes
  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic e);
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = a;
    #1 d = PRDATA; e = PSLVERR;
    #1 PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  initial begin
    errors = 0; checks = 0;
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0;
    pat40 = 10'b0000000111;
    pat41 = 14'b00111111000000;

    // Reset state
    repeat (3) @(negedge PCLK);
    chk("rst_pwm_out", 32'(PWM_OUT), 32'h0);
    chk("rst_pwm_irq", 32'(PWM_IRQ), 32'h0);
    chk("pready", 32'(PREADY), 32'h1);
    PRESET = 1'b0;
    rd(32'h000, rdat, err); chk("rst_ctrl0", rdat, 32'h0);
    rd(32'h004, rdat, err); chk("rst_period0", rdat, 32'h0);
    rd(32'h100, rdat, err); chk("rst_irq_stat", rdat, 32'h0);

    // Ch0 P=10 D=3: 3 high / 7 low, wrap flag every 10 cycles
    w(32'h004, 32'd10); w(32'h008, 32'd3);
    wr(32'h000, 32'h1, err); chk("wr_ok_err", 32'(err), 32'h0);
    rd(32'h00C, rdat, err); chk("c0_count_start", rdat, 32'h0);
    chk("c0_out_start", 32'(PWM_OUT[0]), 32'h0);
    for (int k = 1; k <= 20; k++) begin
      @(negedge PCLK);
      chk("c0_wave", 32'(PWM_OUT[0]), 32'(pat40[(k - 1) % 10]));
      if (k == 9) begin
        rd(32'h100, rdat, err); chk("c0_stat_prewrap", rdat, 32'h0);
      end
      if (k == 10 || k == 20) begin
        rd(32'h100, rdat, err); chk("c0_stat_wrap", rdat, 32'h1);
      end
    end
    chk("c0_no_irq_ie0", 32'(PWM_IRQ), 32'h0);
    w(32'h000, 32'h0); w(32'h100, 32'h1);
    rd(32'h100, rdat, err); chk("c0_w1c", rdat, 32'h0);

    // Ch1 P=8 D=2, DUTY=6 mid-period takes effect after the wrap
    w(32'h014, 32'd8); w(32'h018, 32'd2); w(32'h010, 32'h1);
    w(32'h018, 32'd6);
    chk("c1_pre", 32'(PWM_OUT[1]), 32'h1);
    rd(32'h01C, rdat, err); chk("c1_count", rdat, 32'd2);
    rd(32'h018, rdat, err); chk("c1_duty_shadow", rdat, 32'd6);
    for (int k = 3; k <= 16; k++) begin
      @(negedge PCLK);
      chk("c1_wave", 32'(PWM_OUT[1]), 32'(pat41[k - 3]));
    end
    w(32'h010, 32'h0); w(32'h100, 32'hF);

    // Ch0 POL=1: D=0 gives constant 1, D=7 > P=5 gives constant 0
    w(32'h004, 32'd5); w(32'h008, 32'd0); w(32'h000, 32'h3);
    repeat (6) begin
      @(negedge PCLK); chk("c0_pol_d0", 32'(PWM_OUT[0]), 32'h1);
    end
    w(32'h008, 32'd7);
    repeat (7) @(negedge PCLK);
    repeat (6) begin
      @(negedge PCLK); chk("c0_pol_dbig", 32'(PWM_OUT[0]), 32'h0);
    end
    w(32'h000, 32'h0);
    @(negedge PCLK); chk("c0_pol_off", 32'(PWM_OUT[0]), 32'h0);
    w(32'h100, 32'hF);

    // Ch2 IE=1, P=4: IRQ on, W1C off-wrap clears, W1C on wrap loses
    w(32'h024, 32'd4); w(32'h028, 32'd1); w(32'h020, 32'h5);
    repeat (5) @(negedge PCLK);
    chk("irq_on", 32'(PWM_IRQ), 32'h1);
    w(32'h100, 32'h4);
    chk("irq_hold", 32'(PWM_IRQ), 32'h1);
    @(negedge PCLK); chk("irq_clr", 32'(PWM_IRQ), 32'h0);
    rd(32'h100, rdat, err); chk("stat_reset_by_wrap", rdat, 32'h4);
    repeat (2) @(negedge PCLK);
    w(32'h100, 32'h4);
    rd(32'h100, rdat, err); chk("w1c_vs_wrap", rdat, 32'h4);
    @(negedge PCLK); chk("irq_after_collide", 32'(PWM_IRQ), 32'h1);
    w(32'h020, 32'h0); w(32'h100, 32'hF);
    @(negedge PCLK); chk("irq_final_clr", 32'(PWM_IRQ), 32'h0);

    // Ch0/ch1 P=16 D=8 offset by 2, SYNC=0x3 realigns without IRQ
    w(32'h004, 32'd16); w(32'h008, 32'd8); w(32'h014, 32'd16); w(32'h018, 32'd8);
    w(32'h000, 32'h1); w(32'h010, 32'h1);
    rd(32'h00C, rdat, err); chk("sync_pre_c0", rdat, 32'd2);
    rd(32'h01C, rdat, err); chk("sync_pre_c1", rdat, 32'd0);
    repeat (3) @(negedge PCLK);
    w(32'h104, 32'h3);
    rd(32'h00C, rdat, err); chk("sync_c0", rdat, 32'd0);
    rd(32'h01C, rdat, err); chk("sync_c1", rdat, 32'd0);
    rd(32'h100, rdat, err); chk("sync_no_irq", rdat, 32'h0);
    for (int k = 6; k <= 21; k++) begin
      @(negedge PCLK);
      chk("sync_align", 32'(PWM_OUT[1:0]), (k <= 13) ? 32'h3 : 32'h0);
    end
    rd(32'h100, rdat, err); chk("sync_wrap_align", rdat, 32'h3);
    chk("sync_pwm_irq", 32'(PWM_IRQ), 32'h0);
    w(32'h000, 32'h0); w(32'h010, 32'h0); w(32'h100, 32'hF);

    // Error responses
    wr(32'h00C, 32'h55, err); chk("err_wr_count", 32'(err), 32'h1);
    rd(32'h00C, rdat, err); chk("count_unchanged", rdat, 32'h0);
    chk("rd_count_ok", 32'(err), 32'h0);
    rd(32'h040, rdat, err); chk("err_rd_ch4", 32'(err), 32'h1);
    chk("rd_ch4_zero", rdat, 32'h0);
    wr(32'h044, 32'h77, err); chk("err_wr_ch4", 32'(err), 32'h1);
    rd(32'h108, rdat, err); chk("err_rd_unmapped", 32'(err), 32'h1);
    rd(32'h104, rdat, err); chk("rd_sync_zero", rdat, 32'h0);
    chk("rd_sync_ok", 32'(err), 32'h0);
    rd(32'h004, rdat, err); chk("period0_kept", rdat, 32'd16);

    // Reset mid-run with a colliding write
    w(32'h000, 32'h7);
    repeat (18) @(negedge PCLK);
    chk("pre_rst_irq", 32'(PWM_IRQ), 32'h1);
    PRESET = 1'b1;
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 32'h004; PWDATA = 32'h99;
    @(negedge PCLK);
    chk("rst_mid_out", 32'(PWM_OUT), 32'h0);
    chk("rst_mid_irq", 32'(PWM_IRQ), 32'h0);
    PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    rd(32'h004, rdat, err); chk("rst_beats_wr", rdat, 32'h0);
    rd(32'h000, rdat, err); chk("rst_mid_ctrl", rdat, 32'h0);
    rd(32'h100, rdat, err); chk("rst_mid_stat", rdat, 32'h0);
    rd(32'h00C, rdat, err); chk("rst_mid_count", rdat, 32'h0);
    repeat (3) @(negedge PCLK);
    chk("post_rst_out", 32'(PWM_OUT), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
